pll_cfg_seq: RTL and testbench

PLL_CFG_SEQ -- requirements
Module: pll_cfg_seq

---
 rtl/pll_cfg_seq.sv | 161 ++++++++++++++++
 tb/tb_pll_cfg_seq.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_cfg_seq.sv
// PLL reconfiguration sequencer: on a PAL/NTSC mode change, program the
// M, K and C0 words, start reconfig, then wait for the PLL to re-lock.
module pll_cfg_seq #(
    parameter logic [31:0] K_NTSC   = 32'd2537930535,
    parameter logic [31:0] K_PAL    = 32'd2201376210,
    parameter logic [31:0] M_VAL    = 32'h00000404,
    parameter logic [31:0] C0_VAL   = 32'h00000404,
    parameter logic [19:0] LOCK_TMO = 20'd1048575
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pal,
    input  logic        pll_locked,
    output logic [5:0]  mgmt_address,
    output logic        mgmt_write,
    output logic        mgmt_read,
    output logic [31:0] mgmt_writedata,
    input  logic        mgmt_waitrequest,
    output logic        cfg_busy,
    output logic        cfg_err,
    output logic        cur_pal
);

    typedef enum logic [2:0] {
        IDLE,
        WR_MODE,
        WR_M,
        WR_K,
        WR_C,
        WR_START,
        WAIT_UNLOCK,
        WAIT_LOCK
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  pal_sync_q, lock_sync_q;
    logic        tgt_q, tgt_d;
    logic        cur_pal_q, cur_pal_d;
    logic        busy_q, busy_d;
    logic        err_q, err_d;
    logic [19:0] cnt_q, cnt_d;
    logic        pal_s, lock_s;
    logic        wr_done;

    assign pal_s  = pal_sync_q[1];
    assign lock_s = lock_sync_q[1];

    assign mgmt_read = 1'b0;
    assign cfg_busy  = busy_q;
    assign cfg_err   = err_q;
    assign cur_pal   = cur_pal_q;

    // Two-flop synchronizers for the asynchronous mode and lock inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pal_sync_q  <= 2'b00;
            lock_sync_q <= 2'b00;
        end else begin
            pal_sync_q  <= {pal_sync_q[0], pal};
            lock_sync_q <= {lock_sync_q[0], pll_locked};
        end
    end

    // Sequencer state and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            tgt_q     <= 1'b0;
            cur_pal_q <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
            cnt_q     <= 20'd0;
        end else begin
            state_q   <= state_d;
            tgt_q     <= tgt_d;
            cur_pal_q <= cur_pal_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
        end
    end

    // Next-state logic; bus outputs decode straight from state so they
    // hold steady for as long as the bus stalls.
    always_comb begin
        state_d        = state_q;
        tgt_d          = tgt_q;
        cur_pal_d      = cur_pal_q;
        busy_d         = busy_q;
        err_d          = err_q;
        cnt_d          = cnt_q;
        mgmt_write     = 1'b0;
        mgmt_address   = 6'd0;
        mgmt_writedata = 32'd0;
        wr_done        = !mgmt_waitrequest;
        unique case (state_q)
            IDLE: begin
                if (pal_s != cur_pal_q) begin
                    tgt_d   = pal_s;
                    busy_d  = 1'b1;
                    state_d = WR_MODE;
                end
            end
            WR_MODE: begin
                mgmt_write = 1'b1;
                if (wr_done) state_d = WR_M;
            end
            WR_M: begin
                mgmt_write     = 1'b1;
                mgmt_address   = 6'd4;
                mgmt_writedata = M_VAL;
                if (wr_done) state_d = WR_K;
            end
            WR_K: begin
                mgmt_write     = 1'b1;
                mgmt_address   = 6'd7;
                mgmt_writedata = tgt_q ? K_PAL : K_NTSC;
                if (wr_done) state_d = WR_C;
            end
            WR_C: begin
                mgmt_write     = 1'b1;
                mgmt_address   = 6'd5;
                mgmt_writedata = C0_VAL;
                if (wr_done) state_d = WR_START;
            end
            WR_START: begin
                mgmt_write     = 1'b1;
                mgmt_address   = 6'd2;
                mgmt_writedata = 32'd1;
                if (wr_done) begin
                    cur_pal_d = tgt_q;
                    cnt_d     = 20'd0;
                    state_d   = WAIT_UNLOCK;
                end
            end
            WAIT_UNLOCK: begin
                cnt_d = cnt_q + 20'd1;
                if (!lock_s || cnt_q == 20'd63) begin
                    cnt_d   = 20'd0;
                    state_d = WAIT_LOCK;
                end
            end
            WAIT_LOCK: begin
                cnt_d = cnt_q + 20'd1;
                if (lock_s) begin
                    err_d   = 1'b0;
                    busy_d  = 1'b0;
                    cnt_d   = 20'd0;
                    state_d = IDLE;
                end else if (cnt_d == LOCK_TMO) begin
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    cnt_d   = 20'd0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_pll_cfg_seq.sv
// Scoreboard bench for pll_cfg_seq: expected bus writes are queued by
// the stimulus and popped by a monitor on each accepted write.
`timescale 1ns/1ps
module tb_pll_cfg_seq;

    localparam logic [31:0] KN  = 32'd2537930535;
    localparam logic [31:0] KP  = 32'd2201376210;
    localparam logic [31:0] MV  = 32'h00000404;
    localparam logic [31:0] CV  = 32'h00000404;
    localparam logic [19:0] TMO = 20'd200;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pal;
    logic        pll_locked;
    logic [5:0]  mgmt_address;
    logic        mgmt_write;
    logic        mgmt_read;
    logic [31:0] mgmt_writedata;
    logic        mgmt_waitrequest;
    logic        cfg_busy;
    logic        cfg_err;
    logic        cur_pal;

    int total = 0;
    int bad   = 0;
    int n_stall = 0;
    logic [37:0] exp_q[$];

    pll_cfg_seq #(.LOCK_TMO(TMO)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .pal             (pal),
        .pll_locked      (pll_locked),
        .mgmt_address    (mgmt_address),
        .mgmt_write      (mgmt_write),
        .mgmt_read       (mgmt_read),
        .mgmt_writedata  (mgmt_writedata),
        .mgmt_waitrequest(mgmt_waitrequest),
        .cfg_busy        (cfg_busy),
        .cfg_err         (cfg_err),
        .cur_pal         (cur_pal)
    );

    always #10 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic push_seq(input logic t);
        exp_q.push_back({6'd0, 32'd0});
        exp_q.push_back({6'd4, MV});
        exp_q.push_back({6'd7, t ? KP : KN});
        exp_q.push_back({6'd5, CV});
        exp_q.push_back({6'd2, 32'd1});
    endtask

    task automatic wait_addr(input logic [5:0] a);
        int n = 0;
        while (!(mgmt_write && mgmt_address == a) && n < 300) begin
            step();
            n++;
        end
        if (n >= 300) chk("wait_addr_tmo", 32'(a), 32'hffff);
    endtask

    task automatic wait_start();
        int n = 0;
        while (!(mgmt_write && mgmt_address == 6'd2 && !mgmt_waitrequest)
               && n < 300) begin
            step();
            n++;
        end
        if (n >= 300) chk("start_tmo", 32'(n), 32'd0);
        step();
    endtask

    task automatic wait_idle(input int budget, output int c);
        c = 0;
        while (cfg_busy && c < budget) begin
            step();
            c++;
        end
        if (c >= budget) chk("idle_tmo", 32'(c), 32'd0);
    endtask

    // Monitor: every write seen with waitrequest low retires one entry;
    // stalled cycles must already present the head entry unchanged.
    always @(negedge clk) begin
        if (rst_n && mgmt_write) begin
            total++;
            if (mgmt_read !== 1'b0) begin
                bad++;
                $display("FAIL mgmt_read act=%0b exp=0", mgmt_read);
            end
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write addr=%0d data=%0h",
                         mgmt_address, mgmt_writedata);
            end else begin
                total++;
                if ({mgmt_address, mgmt_writedata} !== exp_q[0]) begin
                    bad++;
                    $display("FAIL write act=%0d/%0h exp=%0d/%0h",
                             mgmt_address, mgmt_writedata,
                             exp_q[0][37:32], exp_q[0][31:0]);
                end
                if (mgmt_waitrequest) n_stall++;
                else void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        rst_n = 1'b0;
        pal = 1'b0;
        pll_locked = 1'b1;
        mgmt_waitrequest = 1'b0;
        #1;
        chk("rst_write", 32'(mgmt_write), 32'd0);
        chk("rst_addr", 32'(mgmt_address), 32'd0);
        chk("rst_data", mgmt_writedata, 32'd0);
        chk("rst_busy", 32'(cfg_busy), 32'd0);
        chk("rst_err", 32'(cfg_err), 32'd0);
        chk("rst_cur", 32'(cur_pal), 32'd0);
        step();
        step();
        rst_n = 1'b1;

        // pal held at 0: nothing to do
        repeat (1000) step();
        chk("idle_busy", 32'(cfg_busy), 32'd0);
        chk("idle_cur", 32'(cur_pal), 32'd0);

        // NTSC -> PAL, lock drops and returns after 100 cycles
        push_seq(1'b1);
        pal = 1'b1;
        wait_addr(6'd0);
        repeat (4) step();
        chk("wr_lat_addr", 32'(mgmt_address), 32'd2);
        chk("wr_lat_wr", 32'(mgmt_write), 32'd1);
        wait_start();
        chk("cur_after_start", 32'(cur_pal), 32'd1);
        chk("busy_mid", 32'(cfg_busy), 32'd1);
        pll_locked = 1'b0;
        repeat (100) step();
        pll_locked = 1'b1;
        wait_idle(50, c);
        chk("lock_to_idle", 32'(c), 32'd3);
        chk("cur_pal_1", 32'(cur_pal), 32'd1);

        // PAL -> NTSC, bounced back to PAL while waiting for lock
        push_seq(1'b0);
        pal = 1'b0;
        wait_start();
        chk("cur_mid_toggle", 32'(cur_pal), 32'd0);
        pll_locked = 1'b0;
        repeat (20) step();
        pal = 1'b1;
        push_seq(1'b1);
        repeat (30) step();
        pll_locked = 1'b1;
        wait_start();
        pll_locked = 1'b0;
        repeat (10) step();
        pll_locked = 1'b1;
        wait_idle(50, c);
        chk("cur_after_toggle", 32'(cur_pal), 32'd1);

        // PAL -> NTSC with a 7-cycle stall on the K write
        push_seq(1'b0);
        pal = 1'b0;
        n_stall = 0;
        wait_addr(6'd7);
        mgmt_waitrequest = 1'b1;
        repeat (7) step();
        mgmt_waitrequest = 1'b0;
        wait_start();
        chk("stall_cycles", 32'(n_stall), 32'd7);
        pll_locked = 1'b0;
        repeat (10) step();
        pll_locked = 1'b1;
        wait_idle(50, c);
        chk("cur_after_stall", 32'(cur_pal), 32'd0);

        // NTSC -> PAL, lock never returns: timeout
        push_seq(1'b1);
        pal = 1'b1;
        wait_start();
        pll_locked = 1'b0;
        wait_idle(1000, c);
        chk("tmo_cycles", 32'(c), 32'd203);
        chk("tmo_err", 32'(cfg_err), 32'd1);
        chk("tmo_busy", 32'(cfg_busy), 32'd0);
        chk("tmo_cur", 32'(cur_pal), 32'd1);

        // next successful sequence clears the error
        push_seq(1'b0);
        pal = 1'b0;
        wait_start();
        chk("err_sticky", 32'(cfg_err), 32'd1);
        repeat (10) step();
        pll_locked = 1'b1;
        wait_idle(50, c);
        chk("err_clear", 32'(cfg_err), 32'd0);
        chk("cur_after_clear", 32'(cur_pal), 32'd0);

        // reset in the middle of the K write, then a full restart
        push_seq(1'b1);
        pal = 1'b1;
        wait_addr(6'd7);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_write", 32'(mgmt_write), 32'd0);
        chk("mid_rst_addr", 32'(mgmt_address), 32'd0);
        chk("mid_rst_data", mgmt_writedata, 32'd0);
        chk("mid_rst_busy", 32'(cfg_busy), 32'd0);
        chk("mid_rst_cur", 32'(cur_pal), 32'd0);
        chk("mid_rst_left", 32'(exp_q.size()), 32'd3);
        exp_q.delete();
        step();
        step();
        rst_n = 1'b1;
        push_seq(1'b1);
        wait_addr(6'd0);
        chk("restart_busy", 32'(cfg_busy), 32'd1);
        wait_start();
        wait_idle(200, c);
        chk("unlock_tmo_cycles", 32'(c), 32'd65);
        chk("restart_cur", 32'(cur_pal), 32'd1);
        chk("restart_err", 32'(cfg_err), 32'd0);

        repeat (5) step();
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
